// File: rtl/priority_encoder_8_3_stream.sv
// priority_encoder_8_3_stream
//
// Sequential 8-to-3 encoder. It accepts an 8-bit request vector through a
// valid/ready handshake. It then emits the 3-bit index of every set bit,
// one index per accepted output beat, in fixed priority order:
// lowest index first when PRIORITY_HIGH = 0, highest index first when
// PRIORITY_HIGH = 1.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  upstream presents in_req
//   in_ready   out  1  block is idle and can take a vector
//   in_req     in   8  request vector, sampled on in_valid && in_ready
//   out_valid  out  1  out_code / out_last are valid
//   out_ready  in   1  downstream accepts the current code
//   out_code   out  3  index of the selected pending bit
//   out_last   out  1  current code is the final one of the vector
//   out_count  out  4  popcount of the last accepted non-zero vector
//   err_empty  out  1  one-cycle pulse after an all-zero vector is accepted
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a vector, in_ready = 1
// EMIT  | presenting codes from pending until the last one is taken

module priority_encoder_8_3_stream #(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic [3:0] out_count,
  output logic       err_empty
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] pending_q;
  logic [3:0] count_q;
  logic       err_q;

  logic       in_fire;
  logic       out_fire;
  logic       zero_req;
  logic [2:0] sel_idx;
  logic       pend_single;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Handshake qualifiers come from registered state only, so out_valid and
  // out_code never depend combinationally on in_* or out_ready.
  assign in_fire  = in_valid && (state_q == IDLE);
  assign out_fire = out_ready && (state_q == EMIT);
  assign zero_req = (in_req == 8'h00);

  // Priority select: the last match in the scan order wins, so scanning
  // downward yields the lowest set bit and upward yields the highest.
  always_comb begin
    sel_idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = 3'(i);
      end
    end
  end

  // Exactly one bit left: non-zero and clearing the lowest set bit gives zero.
  assign pend_single = (pending_q != 8'h00) &&
                       ((pending_q & (pending_q - 8'd1)) == 8'h00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_fire && !zero_req) state_d = EMIT;
      EMIT: if (out_fire && pend_single) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_code  = 3'd0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        out_code  = sel_idx;
        out_last  = pend_single;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Pending bits, popcount and the empty-vector pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 8'h00;
      count_q   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= in_fire && zero_req;
      if (in_fire && !zero_req) begin
        pending_q <= in_req;
        count_q   <= popcount8(in_req);
      end else if (out_fire) begin
        pending_q[sel_idx] <= 1'b0;
      end
    end
  end

  assign out_count = count_q;
  assign err_empty = err_q;

endmodule

// File: doc/priority_encoder_8_3_stream.md
# priority_encoder_8_3_stream

Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 one-hot decoder. It accepts an 8-bit request vector with a valid/ready handshake. It then emits the 3-bit index of every set bit, one index per accepted output beat, in fixed priority order. It sits between request-collecting logic (interrupt lines, arbiter grants) and index-consuming logic such as the decoder, a mux select, or a register-file address.

## Interface
- PRIORITY_HIGH, default 0: 0 emits lowest index first (bit 0 → bit 7); 1 emits highest index first (bit 7 → bit 0).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents in_req.
- in_ready  output  1  block can accept a vector; equals (state == IDLE).
- in_req  input  8  request vector; sampled only on in_valid && in_ready.
- out_valid  output  1  out_code/out_last are valid.
- out_ready  input  1  downstream accepts the current code.
- out_code  output  3  binary index of the selected set bit.
- out_last  output  1  current code is the final one for this vector.
- out_count  output  4  popcount of the last accepted non-zero vector (1..8).
- err_empty  output  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- State register holds IDLE or EMIT. An 8-bit pending register holds the bits not yet emitted.
- IDLE:
  - in_ready = 1, out_valid = 0, out_code = 0, out_last = 0.
  - On in_valid && in_ready with in_req != 0: pending <= in_req, out_count <= popcount(in_req), state <= EMIT.
  - On in_valid && in_ready with in_req == 0: err_empty <= 1 for exactly one cycle. State stays IDLE, pending and out_count are unchanged, and no code is emitted.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_code = index of the lowest set bit of pending (PRIORITY_HIGH=0) or the highest set bit (PRIORITY_HIGH=1).
  - out_last = (popcount(pending) == 1).
  - On out_valid && out_ready: clear the pending bit at out_code. If out_last, state <= IDLE.
  - If out_ready = 0: pending, out_code, out_last and out_count are held stable. A code is never dropped, duplicated or changed while stalled.
- out_code and out_last are combinational from the pending and state registers only. There is no combinational path from in_* or out_ready to out_valid/out_code.
- out_count holds its value after the vector completes and updates only on the next non-zero capture.
- in_req is ignored whenever in_ready = 0.
- Every set bit of an accepted vector is emitted exactly once, in strict priority order. The number of beats equals out_count.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, pending = 0.
  - out_valid = 0, out_code = 0, out_last = 0, out_count = 0, err_empty = 0.
  - in_ready = 1.
- Latency: a vector accepted at rising edge N gives out_valid = 1 from edge N to edge N+1, i.e. the first code is visible in the cycle after acceptance.
- Throughput: one code per cycle while out_ready = 1. A vector with k set bits occupies EMIT for exactly k cycles when there is no backpressure.
- The handshake of the last code at edge M returns state to IDLE, so in_ready = 1 after edge M. There is one mandatory bubble between consecutive vectors; in_ready and out_valid are never both 1.
- err_empty: an all-zero accept at edge N gives err_empty = 1 after edge N for one cycle only. Back-to-back zero accepts give consecutive pulses.
- Reset asserted mid-EMIT immediately drops out_valid and clears pending. No remaining codes of that vector are emitted after reset is released.
- Single-bit vector: one beat with out_last = 1.
- 8'hFF: eight beats, out_count = 8 (4-bit width required).

## Test plan
- Reset check: hold rst_n = 0 with random inputs → out_valid = 0, out_code = 0, out_last = 0, out_count = 0, err_empty = 0, in_ready = 1; deassert → block is IDLE.
- PRIORITY_HIGH=0, in_req = 8'b1010_0100, out_ready = 1 → codes 2, 5, 7 on three consecutive cycles, out_last only with 7, out_count = 3, in_ready = 0 during those cycles and 1 in the following cycle.
- PRIORITY_HIGH=1, same vector → codes 7, 5, 2, out_last with 2.
- in_req = 8'h00 accepted → err_empty high for exactly one cycle, out_valid stays 0, in_ready stays 1, out_count unchanged.
- in_req = 8'hFF with out_ready driven by a pseudo-random pattern → codes 0..7 each exactly once in order, out_code/out_last stable during every stall, out_count = 8, out_last only with 7.
- Reset pulsed after two codes of 8'hFF have been accepted → out_valid = 0 immediately, no further codes of that vector; then in_req = 8'h01 → single code 0 with out_last = 1 and out_count = 1.
